// File: rtl/hough_pkg.sv
// -----------------------------------------------------------------------------
// hough_pkg
// Shared constants and state encoding for the Hough line-detection datapath.
// The upstream Hough FSM and the vote accumulator both import this package.
//   ADDR_W     : vote/bin address width
//   CNT_W      : vote counter width
//   DEPTH      : number of rho bins (2**ADDR_W)
//   RHO_OFFSET : offset the upstream adds to signed rho to form a bin address
// -----------------------------------------------------------------------------
package hough_pkg;

    localparam int ADDR_W     = 11;
    localparam int CNT_W      = 16;
    localparam int DEPTH      = 2048;
    localparam int RHO_OFFSET = 800;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_SCAN   = 3'd3,
        ST_REPORT = 3'd4
    } hough_state_t;

endpackage

// File: rtl/hough_vote_ram.sv
// -----------------------------------------------------------------------------
// hough_vote_ram
// Simple dual-port synchronous RAM holding one vote counter per bin.
// One write port and one read port; read data is registered (1-cycle latency).
// A read and write to the same address on the same edge returns the old data.
//   clock   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, valid one cycle after raddr_i is presented
// -----------------------------------------------------------------------------
module hough_vote_ram #(
    parameter int ADDR_W = hough_pkg::ADDR_W,
    parameter int DATA_W = hough_pkg::CNT_W,
    parameter int DEPTH  = hough_pkg::DEPTH
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hough_vote_accumulator.sv
// -----------------------------------------------------------------------------
// hough_vote_accumulator
// Accumulates Hough votes per rho bin for one frame, then scans all bins and
// reports the bin with the highest count (lowest address on a tie).
// Frame cycle: CLEAR (zero all bins) -> ACCUM (count votes) -> DRAIN (let the
// read-modify-write pipe empty) -> SCAN (find max) -> REPORT -> CLEAR.
//   clock        : clock, rising edge
//   reset        : asynchronous, active-low
//   vote_valid   : one vote per high cycle
//   vote_address : bin to increment
//   frame_done   : level; its rising edge in ACCUM ends the frame
//   busy         : high in CLEAR, DRAIN and SCAN
//   vote_dropped : sticky, set when a vote arrives outside ACCUM
//   peak_valid   : one-cycle pulse when peak_address/peak_count update
//   peak_address : bin with the maximum count (held until next report)
//   peak_count   : count of that bin (held until next report)
// -----------------------------------------------------------------------------
module hough_vote_accumulator #(
    parameter int ADDR_W = hough_pkg::ADDR_W,
    parameter int CNT_W  = hough_pkg::CNT_W,
    parameter int DEPTH  = hough_pkg::DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vote_valid,
    input  logic [ADDR_W-1:0] vote_address,
    input  logic              frame_done,
    output logic              busy,
    output logic              vote_dropped,
    output logic              peak_valid,
    output logic [ADDR_W-1:0] peak_address,
    output logic [CNT_W-1:0]  peak_count
);

    import hough_pkg::*;

    // One counter serves both the CLEAR sweep and the SCAN sweep; the extra
    // bit lets SCAN run past DEPTH while the read/compare pipe empties.
    localparam int            CW         = ADDR_W + 1;
    localparam logic [CW-1:0] CLR_LAST   = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(1);
    localparam logic [CW-1:0] SCAN_RD_N  = CW'(DEPTH);
    localparam logic [CW-1:0] SCAN_LAST  = CW'(DEPTH + 2);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hough_state_t      state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              fd_q;
    logic              fd_rise, vote_acc, scan_rd;

    logic              vote_vld_p0_q;
    logic [ADDR_W-1:0] vote_addr_p0_q;
    logic [CNT_W-1:0]  old_cnt_p0, new_cnt_p0;
    logic              wr_vld_p1_q, wr_vld_p2_q;
    logic [ADDR_W-1:0] wr_addr_p1_q, wr_addr_p2_q;
    logic [CNT_W-1:0]  wr_cnt_p1_q, wr_cnt_p2_q;

    logic              scan_vld_p0_q;
    logic [ADDR_W-1:0] scan_addr_p0_q;
    logic [ADDR_W-1:0] max_addr_q;
    logic [CNT_W-1:0]  max_cnt_q;

    logic              vote_dropped_q, peak_valid_q;
    logic [ADDR_W-1:0] peak_addr_q;
    logic [CNT_W-1:0]  peak_cnt_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [CNT_W-1:0]  ram_wdata, ram_rdata;

    assign fd_rise  = frame_done & ~fd_q;
    assign vote_acc = vote_valid && (state_q == ST_ACCUM);
    assign scan_rd  = (state_q == ST_SCAN) && (cnt_q < SCAN_RD_N);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ACCUM: begin
                cnt_d = '0;
                if (fd_rise) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    state_d = ST_REPORT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_REPORT: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // ---- stage p0: RAM data returns; take the newest value for this bin ----
    // The two previous writes may not be visible in the RAM read yet, so the
    // most recent matching one wins over the RAM data.
    always_comb begin
        old_cnt_p0 = ram_rdata;
        if (wr_vld_p1_q && (wr_addr_p1_q == vote_addr_p0_q)) begin
            old_cnt_p0 = wr_cnt_p1_q;
        end else if (wr_vld_p2_q && (wr_addr_p2_q == vote_addr_p0_q)) begin
            old_cnt_p0 = wr_cnt_p2_q;
        end
        new_cnt_p0 = sat_inc(old_cnt_p0);
    end

    always_comb begin
        ram_we    = vote_vld_p0_q;
        ram_waddr = vote_addr_p0_q;
        ram_wdata = new_cnt_p0;
        ram_raddr = vote_address;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q[ADDR_W-1:0];
            ram_wdata = '0;
        end
        if (state_q == ST_SCAN) begin
            ram_raddr = cnt_q[ADDR_W-1:0];
        end
    end

    hough_vote_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (CNT_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clock   (clock),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_CLEAR;
            cnt_q          <= '0;
            fd_q           <= 1'b0;
            vote_vld_p0_q  <= 1'b0;
            wr_vld_p1_q    <= 1'b0;
            wr_vld_p2_q    <= 1'b0;
            scan_vld_p0_q  <= 1'b0;
            max_addr_q     <= '0;
            max_cnt_q      <= '0;
            vote_dropped_q <= 1'b0;
            peak_valid_q   <= 1'b0;
            peak_addr_q    <= '0;
            peak_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fd_q          <= frame_done;
            vote_vld_p0_q <= vote_acc;
            wr_vld_p1_q   <= vote_vld_p0_q;
            wr_vld_p2_q   <= wr_vld_p1_q;
            scan_vld_p0_q <= scan_rd;
            if (vote_valid && (state_q != ST_ACCUM)) begin
                vote_dropped_q <= 1'b1;
            end
            // Strict greater-than keeps the lowest address on a tie.
            if (state_q == ST_DRAIN) begin
                max_addr_q <= '0;
                max_cnt_q  <= '0;
            end else if (scan_vld_p0_q && (ram_rdata > max_cnt_q)) begin
                max_addr_q <= scan_addr_p0_q;
                max_cnt_q  <= ram_rdata;
            end
            peak_valid_q <= 1'b0;
            if ((state_q == ST_SCAN) && (cnt_q == SCAN_LAST)) begin
                peak_valid_q <= 1'b1;
                peak_addr_q  <= max_addr_q;
                peak_cnt_q   <= max_cnt_q;
            end
        end
    end

    // ---- stage p1/p2: history of committed writes for forwarding ----
    always_ff @(posedge clock) begin
        vote_addr_p0_q <= vote_address;
        scan_addr_p0_q <= cnt_q[ADDR_W-1:0];
        wr_addr_p1_q   <= vote_addr_p0_q;
        wr_cnt_p1_q    <= new_cnt_p0;
        wr_addr_p2_q   <= wr_addr_p1_q;
        wr_cnt_p2_q    <= wr_cnt_p1_q;
    end

    assign busy         = (state_q == ST_CLEAR) || (state_q == ST_DRAIN) || (state_q == ST_SCAN);
    assign vote_dropped = vote_dropped_q;
    assign peak_valid   = peak_valid_q;
    assign peak_address = peak_addr_q;
    assign peak_count   = peak_cnt_q;

endmodule

// File: tb/tb_hough_vote_accumulator.sv
`timescale 1ns/1ps
module tb_hough_vote_accumulator;

    localparam int ADDR_W = 11;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 2048;
    localparam int MAXC   = (1 << CNT_W) - 1;
    localparam int LAT    = 2 + DEPTH + 3;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              vote_valid = 1'b0;
    logic [ADDR_W-1:0] vote_address = '0;
    logic              frame_done = 1'b0;
    logic              busy, vote_dropped, peak_valid;
    logic [ADDR_W-1:0] peak_address;
    logic [CNT_W-1:0]  peak_count;

    typedef struct {
        int     addr;
        int     cnt;
        longint at;
    } exp_t;

    exp_t   exp_q[$];
    int     ref_bins[DEPTH];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     last_addr = 0;
    int     last_cnt = 0;

    hough_vote_accumulator #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .vote_valid   (vote_valid),
        .vote_address (vote_address),
        .frame_done   (frame_done),
        .busy         (busy),
        .vote_dropped (vote_dropped),
        .peak_valid   (peak_valid),
        .peak_address (peak_address),
        .peak_count   (peak_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) ref_bins[i] = 0;
    endtask

    task automatic bump(input int a);
        if (ref_bins[a] < MAXC) ref_bins[a]++;
    endtask

    task automatic vote(input int a);
        vote_valid   = 1'b1;
        vote_address = ADDR_W'(a);
        bump(a);
        tick();
        vote_valid = 1'b0;
    endtask

    // Ends the frame; optionally a final vote shares the frame_done edge cycle.
    task automatic close_frame(input bit with_vote, input int a, input bit expect_report);
        int pa, pc;
        if (with_vote) begin
            vote_valid   = 1'b1;
            vote_address = ADDR_W'(a);
            bump(a);
        end
        frame_done = 1'b1;
        if (expect_report) begin
            pa = 0;
            pc = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (ref_bins[i] > pc) begin
                    pc = ref_bins[i];
                    pa = i;
                end
            end
            exp_q.push_back('{addr: pa, cnt: pc, at: cyc + 1 + LAT});
            last_addr = pa;
            last_cnt  = pc;
        end
        clear_model();
        tick();
        vote_valid = 1'b0;
        tick();
        tick();
        frame_done = 1'b0;
    endtask

    task automatic wait_accum();
        int n;
        n = 0;
        while (!(busy == 1'b0 && peak_valid == 1'b0 && exp_q.size() == 0)) begin
            tick();
            n++;
            if (n > 3 * DEPTH + 200) begin
                fail_now("wait_accum");
                break;
            end
        end
        check("peak_hold_addr", peak_address, last_addr);
        check("peak_hold_count", peak_count, last_cnt);
    endtask

    task automatic measure_clear(output int n);
        n = 0;
        while (n < 4000) begin
            tick();
            n++;
            if (!busy) break;
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (peak_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_peak: got peak_valid=1 addr %0d count %0d, required no report",
                         peak_address, peak_count);
            end else begin
                e = exp_q.pop_front();
                check("peak_address", peak_address, e.addr);
                check("peak_count", peak_count, e.cnt);
                check("peak_cycle", cyc, e.at);
            end
        end
    end

    initial begin : watchdog
        repeat (96000) @(posedge clock);
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n, b1, b2, len;
        clear_model();
        repeat (3) tick();
        check("reset_busy", busy, 1);
        check("reset_peak_valid", peak_valid, 0);
        check("reset_peak_address", peak_address, 0);
        check("reset_peak_count", peak_count, 0);
        check("reset_vote_dropped", vote_dropped, 0);
        reset = 1'b1;
        measure_clear(n);
        check("clear_cycles", n, DEPTH);

        // Empty frame
        wait_accum();
        close_frame(1'b0, 0, 1'b1);
        wait_accum();
        check("no_drop_yet", vote_dropped, 0);

        // Back-to-back same bin, plus a dropped burst during SCAN
        vote(5); vote(5); vote(5); vote(9); vote(9);
        close_frame(1'b0, 0, 1'b1);
        repeat (50) tick();
        vote_valid   = 1'b1;
        vote_address = ADDR_W'(1000);
        repeat (4) tick();
        vote_valid = 1'b0;
        check("vote_dropped_scan", vote_dropped, 1);
        wait (exp_q.size() == 0 || cyc > 40000);
        tick();
        // frame_done edge while clearing must not end a frame
        frame_done = 1'b1;
        repeat (3) tick();
        frame_done = 1'b0;

        // Alternating bins
        wait_accum();
        vote(7); vote(8); vote(7); vote(8); vote(7);
        close_frame(1'b0, 0, 1'b1);

        // Tie; the second vote shares the frame_done edge cycle
        wait_accum();
        vote(100);
        close_frame(1'b1, 50, 1'b1);

        // Reset in the middle of SCAN: no report, full new CLEAR
        wait_accum();
        vote(42); vote(42); vote(1);
        close_frame(1'b0, 0, 1'b0);
        repeat (1000) tick();
        check("busy_mid_scan", busy, 1);
        reset = 1'b0;
        #1;
        check("rst_peak_address", peak_address, 0);
        check("rst_peak_count", peak_count, 0);
        check("rst_peak_valid", peak_valid, 0);
        check("rst_vote_dropped", vote_dropped, 0);
        tick();
        tick();
        reset = 1'b1;
        last_addr = 0;
        last_cnt  = 0;
        measure_clear(n);
        check("clear_after_reset", n, DEPTH);

        // Saturation with random distractor bursts
        wait_accum();
        for (int i = 0; i < MAXC + 3; i++) begin
            vote(3);
            if (i % 1000 == 999) begin
                b1  = int'($urandom_range(0, DEPTH - 1));
                b2  = int'($urandom_range(0, DEPTH - 1));
                len = int'($urandom_range(1, 4));
                for (int k = 0; k < len; k++) vote((k % 2 == 0) ? b1 : b2);
            end
        end
        close_frame(1'b0, 0, 1'b1);
        n = 0;
        while (exp_q.size() != 0 && n < LAT + 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) fail_now("final_report");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
